// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Holds the digit count, the blank segment pattern, the active-low hex
// glyphs in {g,f,e,d,c,b,a} order and the per-slot FSM state type.
package sseg_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

endpackage

// File: rtl/sseg_scan_ctrl_hex2sseg.sv
// Combinational nibble to seven-segment decoder (active-low glyphs).
// Ports:
//   i_nib  in  4  hex value 0-F
//   o_seg  out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module hex2sseg
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = GLYPH_0;
            4'h1: o_seg = GLYPH_1;
            4'h2: o_seg = GLYPH_2;
            4'h3: o_seg = GLYPH_3;
            4'h4: o_seg = GLYPH_4;
            4'h5: o_seg = GLYPH_5;
            4'h6: o_seg = GLYPH_6;
            4'h7: o_seg = GLYPH_7;
            4'h8: o_seg = GLYPH_8;
            4'h9: o_seg = GLYPH_9;
            4'hA: o_seg = GLYPH_A;
            4'hB: o_seg = GLYPH_B;
            4'hC: o_seg = GLYPH_C;
            4'hD: o_seg = GLYPH_D;
            4'hE: o_seg = GLYPH_E;
            4'hF: o_seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
// Each digit owns a slot of REFRESH_DIV clocks; the first BLANK_CYC clocks
// of every slot keep all anodes off to avoid ghosting. Loaded data goes to a
// pending shadow and is applied only at the frame wrap so a frame never
// shows a mix of old and new values.
// Ports:
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   data_in     in   32  nibble k shown on digit k
//   load        in   1   capture strobe for data_in/dp_in/digit_en
//   dp_in       in   8   decimal point per digit, 1 = lit
//   digit_en    in   8   per-digit enable, 0 = dark
//   lz_blank    in   1   leading-zero suppression (live)
//   an          out  8   anodes, active-low
//   seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1   decimal point, active-low
//   frame_done  out  1   one-cycle pulse after each frame wrap
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        lz_blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned   PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DRIVE_FROM = PW'(BLANK_CYC - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    slot_state_t   r_state;
    slot_state_t   w_state_nx;

    logic [31:0] r_act_data;
    logic [7:0]  r_act_dp;
    logic [7:0]  r_act_en;
    logic [31:0] r_pend_data;
    logic [7:0]  r_pend_dp;
    logic [7:0]  r_pend_en;
    logic        r_pend_valid;

    logic        w_tick;
    logic        w_wrap;
    logic        w_upper_zero;
    logic        w_dark;
    logic [3:0]  w_nib;
    logic [6:0]  w_glyph;
    logic [7:0]  w_an_nx;
    logic [6:0]  w_seg_nx;
    logic        w_dp_nx;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wrap = w_tick && (r_idx == 3'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // State is computed from the prescaler value about to be loaded, so that
    // r_state is always DRIVE exactly when r_presc >= BLANK_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_BLANK;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = ST_BLANK;
        if (!w_tick && (r_presc >= DRIVE_FROM)) w_state_nx = ST_DRIVE;
    end

    // Double buffer: a load at the wrap goes straight to the active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '1;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_act_data <= data_in;
                r_act_dp   <= dp_in;
                r_act_en   <= digit_en;
            end else if (r_pend_valid) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_act_en   <= r_pend_en;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_en    <= digit_en;
            r_pend_valid <= 1'b1;
        end
    end

    assign w_nib        = r_act_data[{r_idx, 2'b00} +: 4];
    assign w_upper_zero = ((r_act_data >> {r_idx, 2'b00}) == 32'd0);
    assign w_dark       = !r_act_en[r_idx] ||
                          (lz_blank && (r_idx != 3'd0) && w_upper_zero);

    hex2sseg u_hex2sseg (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_comb begin
        w_an_nx  = 8'hFF;
        w_seg_nx = SEG_BLANK;
        w_dp_nx  = 1'b1;
        if (r_state == ST_DRIVE) begin
            if (!w_dark) w_an_nx[r_idx] = 1'b0;
            w_seg_nx = w_glyph;
            w_dp_nx  = ~r_act_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 8'hFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= w_an_nx;
            seg        <= w_seg_nx;
            dp         <= w_dp_nx;
            frame_done <= w_wrap;
        end
    end

endmodule
